// File: rtl/tns_enc_18_pkg.sv
// Shared constants for the 18-wire TNS encoder and decoder.
// Provides the data width, the 18 wire weights, the codeword cardinality and the FSM encodings.
package tns_enc_18_pkg;

    // Binary data word width; it must hold values up to TNS18_CARD.
    localparam int unsigned BLEN06 = 13;

    // Wire weights. Group n (1..6) carries A (MSB), B, C (LSB).
    // Each weight is the sum of the two below it, so a greedy MSB-first encoding never sets two adjacent wires.
    localparam logic [BLEN06-1:0] TNS01_C = 13'd1;
    localparam logic [BLEN06-1:0] TNS01_B = 13'd2;
    localparam logic [BLEN06-1:0] TNS01_A = 13'd3;
    localparam logic [BLEN06-1:0] TNS02_C = 13'd5;
    localparam logic [BLEN06-1:0] TNS02_B = 13'd8;
    localparam logic [BLEN06-1:0] TNS02_A = 13'd13;
    localparam logic [BLEN06-1:0] TNS03_C = 13'd21;
    localparam logic [BLEN06-1:0] TNS03_B = 13'd34;
    localparam logic [BLEN06-1:0] TNS03_A = 13'd55;
    localparam logic [BLEN06-1:0] TNS04_C = 13'd89;
    localparam logic [BLEN06-1:0] TNS04_B = 13'd144;
    localparam logic [BLEN06-1:0] TNS04_A = 13'd233;
    localparam logic [BLEN06-1:0] TNS05_C = 13'd377;
    localparam logic [BLEN06-1:0] TNS05_B = 13'd610;
    localparam logic [BLEN06-1:0] TNS05_A = 13'd987;
    localparam logic [BLEN06-1:0] TNS06_C = 13'd1597;
    localparam logic [BLEN06-1:0] TNS06_B = 13'd2584;
    localparam logic [BLEN06-1:0] TNS06_A = 13'd4181;

    // Number of legal 18-wire codewords (largest decodable value + 1).
    localparam logic [BLEN06-1:0] TNS18_CARD = 13'd6765;

    // Encoder FSM states.
    typedef enum logic [1:0] {
        TNS_ENC_IDLE = 2'd0,
        TNS_ENC_CALC = 2'd1,
        TNS_ENC_DONE = 2'd2
    } tns_enc_state_t;

endpackage

// File: rtl/tns_enc_18_if.sv
// Valid/ready bus bundle of the 18-wire TNS encoder: data in on one side, codeword out on the other.
interface tns_enc_18_if;
    import tns_enc_18_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [BLEN06-1:0] datain;
    logic              out_valid;
    logic              out_ready;
    logic [17:0]       codeout;
    logic              range_err;

    // Encoder side.
    modport slave (
        input  in_valid, datain, out_ready,
        output in_ready, out_valid, codeout, range_err
    );

    // Upstream/downstream partner side.
    modport master (
        output in_valid, datain, out_ready,
        input  in_ready, out_valid, codeout, range_err
    );
endinterface

// File: rtl/tns_enc_18_grp.sv
// tns_grp_enc: combinational greedy encoder for one 3-wire group.
// Tries A, then B, then C against the running residue and subtracts each weight that fits.
module tns_grp_enc
    import tns_enc_18_pkg::*;
(
    input  logic [BLEN06-1:0] residue,
    input  logic [BLEN06-1:0] w_a,
    input  logic [BLEN06-1:0] w_b,
    input  logic [BLEN06-1:0] w_c,
    output logic [2:0]        bits,
    output logic [BLEN06-1:0] residue_next
);

    logic [BLEN06-1:0] r_after_a;
    logic [BLEN06-1:0] r_after_b;

    // Chained compare/subtract; subtraction only happens when the weight fits, so no underflow.
    always_comb begin
        bits         = 3'b000;
        bits[2]      = (residue >= w_a);
        r_after_a    = bits[2] ? (residue - w_a) : residue;
        bits[1]      = (r_after_a >= w_b);
        r_after_b    = bits[1] ? (r_after_a - w_b) : r_after_a;
        bits[0]      = (r_after_b >= w_c);
        residue_next = bits[0] ? (r_after_b - w_c) : r_after_b;
    end

endmodule

// File: rtl/tns_enc_18.sv
// tns_enc_18: sequential greedy encoder producing an 18-wire TNS codeword, one 3-wire group per cycle.
// IDLE captures a word, CALC resolves groups 5..0 MSB first, DONE holds the result until accepted.
module tns_enc_18
    import tns_enc_18_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    tns_enc_18_if.slave  bus
);

    tns_enc_state_t    state_q, state_d;
    logic [2:0]        grp_q, grp_d;
    logic [BLEN06-1:0] residue_q, residue_d;
    logic [17:0]       codeout_q, codeout_d;
    logic              range_err_q, range_err_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;

    logic [BLEN06-1:0] w_a, w_b, w_c;
    logic [2:0]        grp_bits;
    logic [BLEN06-1:0] grp_res;

    // Select the weight triple of the group currently being resolved.
    always_comb begin
        w_a = '0;
        w_b = '0;
        w_c = '0;
        case (grp_q)
            3'd0:    begin w_a = TNS01_A; w_b = TNS01_B; w_c = TNS01_C; end
            3'd1:    begin w_a = TNS02_A; w_b = TNS02_B; w_c = TNS02_C; end
            3'd2:    begin w_a = TNS03_A; w_b = TNS03_B; w_c = TNS03_C; end
            3'd3:    begin w_a = TNS04_A; w_b = TNS04_B; w_c = TNS04_C; end
            3'd4:    begin w_a = TNS05_A; w_b = TNS05_B; w_c = TNS05_C; end
            3'd5:    begin w_a = TNS06_A; w_b = TNS06_B; w_c = TNS06_C; end
            default: begin w_a = '0;      w_b = '0;      w_c = '0;      end
        endcase
    end

    tns_grp_enc u_grp_enc (
        .residue      (residue_q),
        .w_a          (w_a),
        .w_b          (w_b),
        .w_c          (w_c),
        .bits         (grp_bits),
        .residue_next (grp_res)
    );

    // Next-state logic; out_valid rises one cycle after entering DONE so the handshake sees a settled codeword.
    always_comb begin
        state_d     = state_q;
        grp_d       = grp_q;
        residue_d   = residue_q;
        codeout_d   = codeout_q;
        range_err_d = range_err_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        case (state_q)
            TNS_ENC_IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    residue_d  = bus.datain;
                    codeout_d  = '0;
                    grp_d      = 3'd5;
                    in_ready_d = 1'b0;
                    if (bus.datain >= TNS18_CARD) begin
                        range_err_d = 1'b1;
                        state_d     = TNS_ENC_DONE;
                    end else begin
                        range_err_d = 1'b0;
                        state_d     = TNS_ENC_CALC;
                    end
                end
            end
            TNS_ENC_CALC: begin
                for (int g = 0; g < 6; g++) begin
                    if (grp_q == 3'(g)) codeout_d[3*g +: 3] = grp_bits;
                end
                residue_d = grp_res;
                if (grp_q == 3'd0) begin
                    state_d = TNS_ENC_DONE;
                end else begin
                    grp_d = grp_q - 3'd1;
                end
            end
            TNS_ENC_DONE: begin
                out_valid_d = 1'b1;
                if (out_valid_q && bus.out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = TNS_ENC_IDLE;
                end
            end
            default: begin
                state_d     = TNS_ENC_IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any word in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= TNS_ENC_IDLE;
            grp_q       <= 3'd0;
            residue_q   <= '0;
            codeout_q   <= '0;
            range_err_q <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            grp_q       <= grp_d;
            residue_q   <= residue_d;
            codeout_q   <= codeout_d;
            range_err_q <= range_err_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

`ifndef SYNTHESIS
    // The last group must consume the whole residue for any in-range word.
    always_ff @(posedge clk) begin
        if (rst_n && state_q == TNS_ENC_CALC && grp_q == 3'd0) begin
            assert (grp_res == '0);
        end
    end
`endif

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.codeout   = codeout_q;
    assign bus.range_err = range_err_q;

endmodule
